// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch front end.
`default_nettype none

package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] HALT_WORD   = 32'h0000_0000;
    localparam logic [31:0] RV_NOP      = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/if_id_slot.sv
// if_id_slot: one-entry IF/ID register with valid/ready handshake, flush and load.
`default_nettype none

module if_id_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // Flush beats load beats drain; payload only changes on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// instr_fetch: PC/FSM owner driving a combinational-read instruction memory into an IF/ID slot.
// Optional fetch_count handshake counter enabled by defining IFETCH_PERF_CNT_EN.
`default_nettype none

module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted,
    output logic        fetch_fault
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    // Widened to 33 bits so a pc near 2^32 cannot wrap into range.
    localparam logic [32:0] LAST_FETCH_PC = 33'(IMEM_BYTES - INSTR_BYTES);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_ok;
    logic        slot_free;
    logic        redirect_take;
    logic        load;

    assign redirect_take = redirect_valid && (state_q != BOOT);
    assign fetch_ok      = (state_q == RUN) && (pc_q[1:0] == 2'b00)
                           && ({1'b0, pc_q} <= LAST_FETCH_PC);
    assign slot_free     = !id_valid || id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_take) begin
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (!fetch_ok)
                        state_d = FAULT;
                    else if (slot_free && (imem_instr == HALT_WORD))
                        state_d = HALT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        load = 1'b0;
        pc_d = pc_q;
        if (redirect_take) begin
            pc_d = redirect_pc;
        end else if (fetch_ok && slot_free && (imem_instr != HALT_WORD)) begin
            load = 1'b1;
            pc_d = pc_q + 32'(INSTR_BYTES);
        end
    end

    if_id_slot u_slot (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_take),
        .load_i  (load),
        .instr_i (imem_instr),
        .pc_i    (pc_q),
        .ready_i (id_ready),
        .valid_o (id_valid),
        .instr_o (id_instr),
        .pc_o    (id_pc)
    );

    assign imem_pc     = pc_q;
    assign halted      = (state_q == HALT);
    assign fetch_fault = (state_q == FAULT);

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;

    // A flushed slot is not a handshake, even with id_ready high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_count_q <= 32'h0;
        else if (id_valid && id_ready && !redirect_take)
            fetch_count_q <= fetch_count_q + 32'd1;
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven and randomized self-checking bench for instr_fetch.
`default_nettype none

module tb_instr_fetch;
    import ifetch_pkg::*;

    localparam int unsigned MEM_BYTES = 32;
    localparam logic [31:0] I0 = 32'hFFC4_A303;
    localparam logic [31:0] I1 = 32'h4139_03B3;
    localparam logic [31:0] I2 = 32'h0094_0333;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;
    logic        fetch_fault;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [8];

    always #5 clk = ~clk;

    assign imem_instr = (imem_pc < MEM_BYTES) ? mem[imem_pc[4:2]] : 32'hDEAD_BEEF;

    instr_fetch #(.RESET_PC(32'h0), .IMEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        h;
        logic        f;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t row(input logic rdy, input logic rd, input logic [31:0] rpc,
                                 input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic h, input logic f, input logic [31:0] ipc);
        vec_t r;
        r.rdy = rdy; r.rd = rd; r.rpc = rpc; r.v = v; r.pc = pc; r.ins = ins;
        r.h = h; r.f = f; r.ipc = ipc;
        return r;
    endfunction

    // 0: fetchable, 1: ends in halt, 2: ends in fault
    function automatic int kind_of(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a > MEM_BYTES - 4) return 2;
        if (mem[a[4:2]] == 32'h0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] pick_target();
        int r;
        r = $urandom_range(0, 15);
        if (r < 10) return 32'(r * 4);
        if (r < 13) return 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
        if (r == 13) return 32'hFFFF_FFFC;
        return $urandom;
    endfunction

    task automatic load_program();
        mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[3] = 32'h0;
        for (int i = 4; i < 8; i++) mem[i] = RV_NOP;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          quiet;
        int          hs;
        int          k;

        reset = 1'b1;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        load_program();

        tbl[0]  = row(1, 0, 0,  0, 0, 0,  0, 0, 0);
        tbl[1]  = row(1, 0, 0,  1, 0, I0, 0, 0, 4);
        tbl[2]  = row(1, 0, 0,  1, 4, I1, 0, 0, 8);
        tbl[3]  = row(1, 0, 0,  1, 8, I2, 0, 0, 12);
        tbl[4]  = row(1, 0, 0,  0, 0, 0,  1, 0, 12);
        tbl[5]  = row(1, 0, 0,  0, 0, 0,  1, 0, 12);
        tbl[6]  = row(1, 1, 4,  0, 0, 0,  0, 0, 4);
        tbl[7]  = row(1, 0, 0,  1, 4, I1, 0, 0, 8);
        tbl[8]  = row(1, 0, 0,  1, 8, I2, 0, 0, 12);
        tbl[9]  = row(1, 0, 0,  0, 0, 0,  1, 0, 12);
        tbl[10] = row(0, 1, 0,  0, 0, 0,  0, 0, 0);
        tbl[11] = row(0, 0, 0,  1, 0, I0, 0, 0, 4);
        tbl[12] = row(0, 0, 0,  1, 0, I0, 0, 0, 4);
        tbl[13] = row(0, 0, 0,  1, 0, I0, 0, 0, 4);
        tbl[14] = row(0, 0, 0,  1, 0, I0, 0, 0, 4);
        tbl[15] = row(1, 0, 0,  1, 4, I1, 0, 0, 8);
        tbl[16] = row(1, 1, 0,  0, 0, 0,  0, 0, 0);
        tbl[17] = row(0, 0, 0,  1, 0, I0, 0, 0, 4);
        tbl[18] = row(1, 1, 8,  0, 0, 0,  0, 0, 8);
        tbl[19] = row(1, 0, 0,  1, 8, I2, 0, 0, 12);
        tbl[20] = row(1, 0, 0,  0, 0, 0,  1, 0, 12);
        tbl[21] = row(1, 1, 6,  0, 0, 0,  0, 0, 6);
        tbl[22] = row(1, 0, 0,  0, 0, 0,  0, 1, 6);
        tbl[23] = row(1, 1, 32, 0, 0, 0,  0, 0, 32);
        tbl[24] = row(1, 0, 0,  0, 0, 0,  0, 1, 32);
        tbl[25] = row(1, 1, 0,  0, 0, 0,  0, 0, 0);
        tbl[26] = row(1, 0, 0,  1, 0, I0, 0, 0, 4);
        tbl[27] = row(1, 0, 0,  1, 4, I1, 0, 0, 8);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", id_valid, 0);
        chk("rst_instr", id_instr, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_imem_pc", imem_pc, 0);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_count", fetch_count, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            id_ready       = tbl[i].rdy;
            redirect_valid = tbl[i].rd;
            redirect_pc    = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), id_valid, tbl[i].v);
            chk($sformatf("row%0d_halted", i), halted, tbl[i].h);
            chk($sformatf("row%0d_fault", i), fetch_fault, tbl[i].f);
            chk($sformatf("row%0d_imem_pc", i), imem_pc, tbl[i].ipc);
            if (tbl[i].v) begin
                chk($sformatf("row%0d_id_pc", i), id_pc, tbl[i].pc);
                chk($sformatf("row%0d_id_instr", i), id_instr, tbl[i].ins);
            end
        end

        // Asynchronous reset with a valid slot, then redirect held through BOOT
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst_valid", id_valid, 0);
        chk("midrst_imem_pc", imem_pc, 0);
`ifdef IFETCH_PERF_CNT_EN
        chk("midrst_count", fetch_count, 0);
`endif
        redirect_valid = 1'b1;
        redirect_pc = 32'd8;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("boot_valid", id_valid, 0);
        chk("boot_imem_pc", imem_pc, 0);
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("boot_first_valid", id_valid, 1);
        chk("boot_first_pc", id_pc, 0);
        chk("boot_first_instr", id_instr, I0);
        repeat (3) @(posedge clk);
        #1;
        chk("prog_halted", halted, 1);
        chk("prog_valid", id_valid, 0);
        chk("prog_imem_pc", imem_pc, 12);
`ifdef IFETCH_PERF_CNT_EN
        chk("prog_count", fetch_count, 3);
`endif

        // Randomized phases against an address-stream reference model
        for (int ph = 0; ph < 3; ph++) begin
            @(negedge clk);
            reset = 1'b1;
            id_ready = 1'b0;
            redirect_valid = 1'b0;
            for (int i = 0; i < 8; i++)
                mem[i] = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom | 32'h1);
            @(negedge clk);
            reset = 1'b0;
            exp_pc = 32'h0;
            quiet = 0;
            hs = 0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                k = kind_of(exp_pc);
                if (id_valid) begin
                    quiet = 0;
                    chk("rnd_fetchable", 1, (k == 0) ? 1 : 0);
                    chk("rnd_id_pc", id_pc, exp_pc);
                    chk("rnd_id_instr", id_instr, mem[exp_pc[4:2]]);
                end else begin
                    quiet++;
                    if (quiet >= 2) begin
                        if (k == 0) begin
                            chk("rnd_progress", id_valid, 1);
                        end else begin
                            chk("rnd_halted", halted, (k == 1) ? 1 : 0);
                            chk("rnd_fault", fetch_fault, (k == 2) ? 1 : 0);
                        end
                    end
                end
                id_ready = ($urandom_range(0, 9) < 7);
                redirect_valid = 1'b0;
                if (!(id_valid && id_ready) && $urandom_range(0, 9) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc = pick_target();
                    exp_pc = redirect_pc;
                    quiet = 0;
                end else if (id_valid && id_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    hs++;
                end
            end
            @(negedge clk);
            redirect_valid = 1'b0;
            id_ready = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
            chk("rnd_count", fetch_count, 32'(hs));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch-side initiator for the byte-addressed, little-endian, combinational-read instruction memory. It owns the program counter and drives the fetch address, then captures the returned 32-bit word into a one-entry IF/ID slot with a valid/ready handshake toward decode. It handles branch/jump redirects, an end-of-program halt (all-zero word) and an address fault.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
IMEM_BYTES, 32, instruction memory size in bytes; must be a multiple of 4.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset; also the memory's load strobe
imem_pc  out  32  fetch byte address to instruction memory
imem_instr  in  32  word at imem_pc, valid in the same cycle (combinational)
redirect_valid  in  1  take redirect_pc next cycle; flushes the slot
redirect_pc  in  32  redirect target byte address
id_ready  in  1  decode accepts id_* this cycle
id_valid  out  1  IF/ID slot holds an instruction
id_instr  out  32  fetched instruction
id_pc  out  32  address of id_instr
halted  out  1  all-zero word fetched; fetch stopped
fetch_fault  out  1  pc misaligned or out of range; fetch stopped

Behaviour:
- While reset is high (async): pc=RESET_PC, state=BOOT, id_valid=0, id_instr=0, id_pc=0, halted=0, fetch_fault=0.
- imem_pc = pc (registered; no combinational path from inputs).
- States: BOOT, RUN, HALT, FAULT.
- BOOT: spends exactly one cycle after reset deasserts with no fetch, so memory contents are stable. Then goes to RUN.
- fetch_ok = state==RUN && pc[1:0]==0 && pc <= IMEM_BYTES-4. Compare in 33 bits so there is no wrap.
- slot_free = !id_valid || id_ready.
- RUN with fetch_ok, slot_free, no redirect, and imem_instr != 0:
  - id_instr<=imem_instr, id_pc<=pc, id_valid<=1.
  - pc<=pc+4, modulo 2^32.
  - Latency: address to id_valid is 1 cycle. Throughput is 1 instruction per cycle while id_ready=1.
- RUN with fetch_ok, slot_free, and imem_instr == 0: no capture; state<=HALT, halted<=1. If the slot was consumed this cycle, id_valid<=0.
- RUN with !fetch_ok: state<=FAULT, fetch_fault<=1, no capture. A valid slot stays until consumed.
- Slot full and id_ready=0: id_* hold stable and pc holds (stall).
- redirect_valid=1 in any state except BOOT has highest priority:
  - pc<=redirect_pc, id_valid<=0 (the slot is flushed even if id_ready=1), state<=RUN, halted<=0, fetch_fault<=0.
  - No capture in the redirect cycle. The first fetch from the target becomes visible 1 cycle after that.
- A redirect during BOOT is ignored.
- HALT and FAULT: id_* drain normally (id_valid falls after the handshake). pc holds. Both states are left only by redirect or reset.
- Reset mid-operation: immediate return to the reset values; any in-flight slot is lost.

Optional Feature:
IFETCH_PERF_CNT_EN.
- Defined: adds output fetch_count[31:0]. It resets to 0, increments on each id_valid&&id_ready handshake, wraps at 2^32, and is not cleared by redirect.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package ifetch_pkg:
  - state enum {BOOT, RUN, HALT, FAULT}
  - INSTR_BYTES=4
  - HALT_WORD=32'h0000_0000
  - RV_NOP=32'h0000_0013 (bench filler)
- One sub-module, if_id_slot: the one-entry valid/ready register holding instr and pc, with flush and load controls. PC and FSM logic stay in instr_fetch.

Test Plan:
- Reset, then bench memory FFC4A303 at 0, 413903B3 at 4, 00940333 at 8, 0 at 12; id_ready=1 -> one BOOT cycle, then id_instr FFC4A303/413903B3/00940333 with id_pc 0/4/8 on consecutive cycles. Next cycle halted=1, id_valid=0, imem_pc holds 12.
- Same program, id_ready=0 for 3 cycles after the first capture -> id_instr holds FFC4A303, id_pc=0, imem_pc=4 stable. On release, 413903B3 follows the next cycle.
- Redirect to 8 while the slot holds pc 0 with id_ready=1 -> slot flushed (no handshake), next capture id_pc=8, 00940333.
- In HALT, redirect_pc=4 -> halted=0, capture 413903B3 then 00940333, then halt again.
- Redirect to 6 -> fetch_fault=1, no capture. Redirect to 32 (IMEM_BYTES) -> fault. Redirect to 0 -> fault clears, fetch resumes at 0.
- Assert reset for 1 cycle mid-stream with the slot valid -> id_valid=0 at once, imem_pc=0. With IFETCH_PERF_CNT_EN, fetch_count=0, then it counts 3 for the first program.
